// File: rtl/cmul_pipe.sv
// cmul_pipe: multiplies an unsigned operand by a small constant (0,1,2,3,4,5,6,12)
// chosen by mode. The constant is split into at most two power-of-two terms. The two
// shifted copies are added limb by limb with no carry between limbs. The result is a
// redundant limb vector carried through LAT valid/ready pipeline stages.
module cmul_pipe #(
  parameter int W   = 254,
  parameter int DIV = 8,
  parameter int LW  = 33,
  parameter int LAT = 1,
  parameter int TW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            mode,
  input  logic [W-1:0]          din,
  input  logic [TW-1:0]         tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIV*(LW+1)-1:0] dout,
  output logic [TW-1:0]         out_tag,
  output logic [2:0]            out_mode
);

  localparam int PW = DIV * LW;
  localparam int OW = DIV * (LW + 1);

  if (PW < W + 4) begin : g_chk_lw
    $error("cmul_pipe: DIV*LW=%0d must be at least W+4=%0d", PW, W + 4);
  end

  if (LAT < 1 || LAT > 3) begin : g_chk_lat
    $error("cmul_pipe: LAT=%0d outside 1..3", LAT);
  end

  // Term decode for each constant: {use_a, shift_a[1:0], use_b, shift_b[1:0]}
  function automatic logic [5:0] terms(input logic [2:0] m);
    case (m)
      3'd0:    terms = 6'b0_00_0_00;  // 0x
      3'd1:    terms = 6'b1_00_0_00;  // 1x
      3'd2:    terms = 6'b1_00_1_00;  // 1x + 1x
      3'd3:    terms = 6'b1_00_1_01;  // 1x + 2x
      3'd4:    terms = 6'b1_10_0_00;  // 4x
      3'd5:    terms = 6'b1_00_1_10;  // 1x + 4x
      3'd6:    terms = 6'b1_01_1_10;  // 2x + 4x
      default: terms = 6'b1_10_1_11;  // 4x + 8x = 12x
    endcase
  endfunction

  logic [5:0]    term_p0;
  logic [PW-1:0] ext_p0;
  logic [PW-1:0] a_p0;
  logic [PW-1:0] b_p0;
  logic [OW-1:0] sum_p0;

  assign ext_p0 = PW'(din);

  // Form both shifted terms and add them limb by limb; each limb keeps its own carry bit
  always_comb begin
    term_p0 = terms(mode);
    a_p0    = term_p0[5] ? (ext_p0 << term_p0[4:3]) : '0;
    b_p0    = term_p0[2] ? (ext_p0 << term_p0[1:0]) : '0;
    sum_p0  = '0;
    for (int i = 0; i < DIV; i++) begin
      sum_p0[i*(LW+1) +: LW+1] = {1'b0, a_p0[i*LW +: LW]} + {1'b0, b_p0[i*LW +: LW]};
    end
  end

  // ---- stage 1 .. LAT: registered limbs, later stages only carry data forward ----
  logic            advance;
  logic [LAT:1]    vld_pn;
  logic [OW-1:0]   dat_pn  [1:LAT];
  logic [TW-1:0]   tag_pn  [1:LAT];
  logic [2:0]      mode_pn [1:LAT];

  assign out_valid = vld_pn[LAT];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // Valid bits: cleared by reset, shifted as a whole whenever the output slot frees up
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pn <= '0;
    end else if (advance) begin
      vld_pn[1] <= in_valid;
      for (int i = 2; i <= LAT; i++) begin
        vld_pn[i] <= vld_pn[i-1];
      end
    end
  end

  // Data, tag and mode move with their valid bit; contents are don't-care when invalid
  always_ff @(posedge clk) begin
    if (advance) begin
      dat_pn[1]  <= sum_p0;
      tag_pn[1]  <= tag;
      mode_pn[1] <= mode;
      for (int i = 2; i <= LAT; i++) begin
        dat_pn[i]  <= dat_pn[i-1];
        tag_pn[i]  <= tag_pn[i-1];
        mode_pn[i] <= mode_pn[i-1];
      end
    end
  end

  // ---- output: result ports read zero whenever no result is present ----
  always_comb begin
    dout     = out_valid ? dat_pn[LAT]  : '0;
    out_tag  = out_valid ? tag_pn[LAT]  : '0;
    out_mode = out_valid ? mode_pn[LAT] : '0;
  end

endmodule

// File: tb/tb_cmul_pipe.sv
// tb_cmul_pipe: three small instances (W=16, DIV=2, LW=10, LAT=1/2/3) share one
// directed stimulus; one default-parameter instance (LAT=2) gets random traffic.
// Each instance has an acceptance-order scoreboard that predicts every result
// from c*din and from the limb definition.
module tb_cmul_pipe;

  localparam int SOW = 22;
  localparam int DOW = 8 * 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared stimulus for small instances
  logic        rst, in_valid, out_ready;
  logic [2:0]  mode;
  logic [15:0] din;
  logic [3:0]  tag;

  logic           in_ready_s  [1:3];
  logic           out_valid_s [1:3];
  logic [SOW-1:0] dout_s      [1:3];
  logic [3:0]     otag_s      [1:3];
  logic [2:0]     omode_s     [1:3];

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    cmul_pipe #(.W(16), .DIV(2), .LW(10), .LAT(g), .TW(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s[g]),
      .mode(mode), .din(din), .tag(tag), .out_valid(out_valid_s[g]),
      .out_ready(out_ready), .dout(dout_s[g]), .out_tag(otag_s[g]), .out_mode(omode_s[g])
    );
  end

  // default-parameter instance
  logic           d_valid, d_rdy, d_ready, d_ov, d_done;
  logic [2:0]     d_mode, d_omode;
  logic [253:0]   d_din;
  logic [3:0]     d_tag, d_otag;
  logic [DOW-1:0] d_dout;

  cmul_pipe #(.LAT(2)) u_def (
    .clk(clk), .rst(rst), .in_valid(d_valid), .in_ready(d_rdy),
    .mode(d_mode), .din(d_din), .tag(d_tag), .out_valid(d_ov),
    .out_ready(d_ready), .dout(d_dout), .out_tag(d_otag), .out_mode(d_omode)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic int unsigned cval(input logic [2:0] m);
    case (m)
      3'd0: return 0;
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 3;
      3'd4: return 4;
      3'd5: return 5;
      3'd6: return 6;
      default: return 12;
    endcase
  endfunction

  // limb vector for W=16, DIV=2, LW=10 from the two-term decomposition
  function automatic logic [SOW-1:0] exp_small(input logic [2:0] m, input logic [15:0] d);
    logic [19:0] a, b, x;
    logic [10:0] l0, l1;
    x = 20'(d);
    case (m)
      3'd0: begin a = '0;      b = '0;      end
      3'd1: begin a = x;       b = '0;      end
      3'd2: begin a = x;       b = x;       end
      3'd3: begin a = x;       b = x << 1;  end
      3'd4: begin a = x << 2;  b = '0;      end
      3'd5: begin a = x;       b = x << 2;  end
      3'd6: begin a = x << 1;  b = x << 2;  end
      default: begin a = x << 2; b = x << 3; end
    endcase
    l0 = 11'(a[9:0]) + 11'(b[9:0]);
    l1 = 11'(a[19:10]) + 11'(b[19:10]);
    return {l1, l0};
  endfunction

  // small-instance scoreboards
  logic [2:0]  q_mode [1:3][0:63];
  logic [15:0] q_din  [1:3][0:63];
  logic [3:0]  q_tag  [1:3][0:63];
  int          q_cyc  [1:3][0:63];
  int          q_st   [1:3][0:63];
  int wp[1:3], rp[1:3], stc[1:3], pops[1:3], first_pop[1:3], last_pop[1:3];
  logic shown[1:3], pstall[1:3], pvld[1:3];
  logic [SOW-1:0] pdout[1:3];
  logic [3:0] ptag[1:3];
  logic [2:0] pmode[1:3];

  // default-instance scoreboard
  logic [2:0]   dq_mode [0:63];
  logic [253:0] dq_din  [0:63];
  logic [3:0]   dq_tag  [0:63];
  int dwp = 0, drp = 0;
  logic dpstall = 1'b0;
  logic [DOW-1:0] dpdout;
  logic [3:0] dptag;
  logic [2:0] dpmode;

  initial begin
    for (int k = 1; k <= 3; k++) begin
      wp[k] = 0; rp[k] = 0; stc[k] = 0; pops[k] = 0; first_pop[k] = -1; last_pop[k] = -1;
      shown[k] = 1'b0; pstall[k] = 1'b0;
    end
  end

  // Compare process: every negative edge, check all outputs against the scoreboards
  always @(negedge clk) begin
    int h, recon, age;
    logic [SOW-1:0] ev;
    logic [299:0] acc, expv;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("in_ready_L%0d", k), in_ready_s[k], !out_valid_s[k] || out_ready);
      if (pstall[k]) begin
        chk($sformatf("stall_vld_L%0d", k), out_valid_s[k], pvld[k]);
        chk($sformatf("stall_dout_L%0d", k), dout_s[k], pdout[k]);
        chk($sformatf("stall_tag_L%0d", k), otag_s[k], ptag[k]);
        chk($sformatf("stall_mode_L%0d", k), omode_s[k], pmode[k]);
      end
      if (out_valid_s[k]) begin
        if (wp[k] == rp[k]) begin
          chk($sformatf("stale_vld_L%0d", k), out_valid_s[k], 1'b0);
        end else begin
          h  = rp[k] % 64;
          ev = exp_small(q_mode[k][h], q_din[k][h]);
          chk($sformatf("dout_L%0d", k), dout_s[k], ev);
          chk($sformatf("tag_L%0d", k), otag_s[k], q_tag[k][h]);
          chk($sformatf("mode_L%0d", k), omode_s[k], q_mode[k][h]);
          recon = int'(dout_s[k][21:11]) * 1024 + int'(dout_s[k][10:0]);
          chk($sformatf("sum_L%0d", k), recon, cval(q_mode[k][h]) * int'(q_din[k][h]));
          if (!shown[k]) begin
            shown[k] = 1'b1;
            age = cyc - q_cyc[k][h];
            if (stc[k] == q_st[k][h]) chk($sformatf("latency_L%0d", k), age, k);
            else chk($sformatf("latency_min_L%0d", k), age >= k, 1'b1);
          end
        end
      end
      pstall[k] = out_valid_s[k] && !out_ready && !rst;
      pvld[k] = out_valid_s[k]; pdout[k] = dout_s[k]; ptag[k] = otag_s[k]; pmode[k] = omode_s[k];
      if (rst) begin
        rp[k] = wp[k];
        shown[k] = 1'b0;
      end else begin
        if (out_valid_s[k] && out_ready && wp[k] != rp[k]) begin
          rp[k]++; shown[k] = 1'b0; pops[k]++;
          if (first_pop[k] < 0) first_pop[k] = cyc;
          last_pop[k] = cyc;
        end
        if (out_valid_s[k] && !out_ready) stc[k]++;
        if (in_valid && in_ready_s[k]) begin
          h = wp[k] % 64;
          q_mode[k][h] = mode; q_din[k][h] = din; q_tag[k][h] = tag;
          q_cyc[k][h] = cyc; q_st[k][h] = stc[k];
          wp[k]++;
        end
      end
    end

    // default instance
    chk("in_ready_D", d_rdy, !d_ov || d_ready);
    if (dpstall) begin
      chk("stall_dout_lo_D", d_dout[63:0], dpdout[63:0]);
      chk("stall_dout_hi_D", d_dout[DOW-1:DOW-64], dpdout[DOW-1:DOW-64]);
      chk("stall_tag_D", d_otag, dptag);
      chk("stall_mode_D", d_omode, dpmode);
    end
    if (d_ov) begin
      if (dwp == drp) begin
        chk("stale_vld_D", d_ov, 1'b0);
      end else begin
        h = drp % 64;
        chk("tag_D", d_otag, dq_tag[h]);
        chk("mode_D", d_omode, dq_mode[h]);
        acc = '0;
        for (int i = 0; i < 8; i++) acc = acc + (300'(d_dout[i*34 +: 34]) << (i * 33));
        expv = 300'(dq_din[h]) * 300'(cval(dq_mode[h]));
        total++;
        if (acc !== expv) begin
          bad++;
          $display("FAIL sum_D actual=%0h required=%0h", acc, expv);
        end
      end
    end
    dpstall = d_ov && !d_ready && !rst;
    dpdout = d_dout; dptag = d_otag; dpmode = d_omode;
    if (rst) begin
      drp = dwp;
    end else begin
      if (d_ov && d_ready && dwp != drp) drp++;
      if (d_valid && d_rdy) begin
        h = dwp % 64;
        dq_mode[h] = d_mode; dq_din[h] = d_din; dq_tag[h] = d_tag;
        dwp++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Random traffic for the default-parameter instance
  initial begin
    logic [255:0] r;
    d_valid = 1'b0; d_ready = 1'b1; d_done = 1'b0; d_mode = '0; d_din = '0; d_tag = '0;
    repeat (3) tick;
    for (int n = 0; n < 20000; n++) begin
      for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
      d_din   = ($urandom_range(0, 7) == 0) ? '1 : r[253:0];
      d_mode  = 3'($urandom_range(0, 7));
      d_tag   = 4'($urandom_range(0, 15));
      d_valid = ($urandom_range(0, 3) != 0);
      d_ready = ($urandom_range(0, 3) != 0);
      tick;
    end
    d_valid = 1'b0; d_ready = 1'b1;
    repeat (6) tick;
    d_done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Directed sequence for the small instances
  initial begin
    int bstart;
    int pbase[1:3];
    rst = 1'b1; in_valid = 1'b0; mode = '0; din = '0; tag = '0; out_ready = 1'b1;
    tick; tick;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("rst_vld_L%0d", k), out_valid_s[k], 1'b0);
      chk($sformatf("rst_rdy_L%0d", k), in_ready_s[k], 1'b1);
      chk($sformatf("rst_dout_L%0d", k), dout_s[k], '0);
      chk($sformatf("rst_tag_L%0d", k), otag_s[k], '0);
      chk($sformatf("rst_mode_L%0d", k), omode_s[k], '0);
    end
    chk("rst_vld_D", d_ov, 1'b0);
    rst = 1'b0;

    // 12 x 0xFFFF
    mode = 3'd7; din = 16'hFFFF; tag = 4'd1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("m7_vld_L1", out_valid_s[1], 1'b1);
    chk("m7_dout_L1", dout_s[1], {11'h2FE, 11'h7F4});
    chk("m7_tag_L1", otag_s[1], 4'd1);
    chk("m7_early_L2", out_valid_s[2], 1'b0);
    tick;
    chk("m7_vld_L2", out_valid_s[2], 1'b1);
    chk("m7_dout_L2", dout_s[2], {11'h2FE, 11'h7F4});
    tick;
    chk("m7_vld_L3", out_valid_s[3], 1'b1);
    chk("m7_dout_L3", dout_s[3], {11'h2FE, 11'h7F4});

    // 3 x 0x0155 and 0 x 0xABCD
    mode = 3'd3; din = 16'h0155; tag = 4'd2; in_valid = 1'b1;
    tick;
    chk("m3_dout_L1", dout_s[1], {11'h000, 11'h3FF});
    mode = 3'd0; din = 16'hABCD; tag = 4'd3;
    tick;
    in_valid = 1'b0;
    chk("m0_vld_L1", out_valid_s[1], 1'b1);
    chk("m0_dout_L1", dout_s[1], '0);
    chk("m0_tag_L1", otag_s[1], 4'd3);
    repeat (4) tick;

    // back-to-back burst, tags 0..7
    for (int k = 1; k <= 3; k++) begin first_pop[k] = -1; pbase[k] = pops[k]; end
    bstart = cyc;
    for (int i = 0; i < 8; i++) begin
      tag = 4'(i); mode = 3'($urandom_range(0, 7)); din = 16'($urandom); in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    repeat (5) tick;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("burst_first_L%0d", k), first_pop[k] - bstart, k);
      chk($sformatf("burst_count_L%0d", k), pops[k] - pbase[k], 8);
      chk($sformatf("burst_span_L%0d", k), last_pop[k] - first_pop[k], 7);
    end

    // stall for 5 cycles after the first LAT=2 result
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tag = 4'(i); mode = 3'($urandom_range(0, 7)); din = 16'($urandom);
      in_valid = (i < 10);
      if (i == 2) out_ready = 1'b0;
      if (i == 7) out_ready = 1'b1;
      #1;
      if (i >= 2 && i < 7) begin
        chk($sformatf("stall_rdy_L2_%0d", i), in_ready_s[2], 1'b0);
        chk($sformatf("stall_ov_L2_%0d", i), out_valid_s[2], 1'b1);
      end
      tick;
    end
    in_valid = 1'b0;
    repeat (8) tick;
    for (int k = 1; k <= 3; k++) chk($sformatf("stall_drain_L%0d", k), wp[k] - rp[k], 0);

    // reset with two results in flight and a request in the reset cycle
    for (int i = 0; i < 2; i++) begin
      tag = 4'(10 + i); mode = 3'd5; din = 16'(1000 * (i + 1)); in_valid = 1'b1;
      tick;
    end
    rst = 1'b1; tag = 4'd9;
    tick;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("midrst_vld_L%0d", k), out_valid_s[k], 1'b0);
      chk($sformatf("midrst_rdy_L%0d", k), in_ready_s[k], 1'b1);
    end
    rst = 1'b0; in_valid = 1'b0;
    repeat (6) tick;

    // random traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mode = 3'($urandom_range(0, 7)); din = 16'($urandom); tag = 4'($urandom_range(0, 15));
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick;
    for (int k = 1; k <= 3; k++) chk($sformatf("final_drain_L%0d", k), wp[k] - rp[k], 0);

    wait (d_done);
    tick;
    chk("final_drain_D", dwp - drp, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
